// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller.
package if_fetch_ctrl_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- presented to IF/ID whenever no real word has been fetched
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_timeout.sv
// Saturating wait-cycle counter for the fetch controller.
// o_expired is asserted combinationally in the WAIT cycle whose increment
// would bring the count to TIMEOUT_CYCLES; TIMEOUT_CYCLES = 0 never expires.
module if_fetch_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles; clear has priority; saturate at CNT_MAX
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding request to a variable-latency
// instruction memory, buffers the returned word for IF/ID, back-pressures the
// PC and squashes in-flight fetches on a redirect.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned INST_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic              id_ready,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ready,
    input  logic [INST_W-1:0] im_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_stall,
    output logic              fetch_err
);

    fetch_state_e      r_state,      w_state_nxt;
    logic              r_im_req,     w_im_req_nxt;
    logic [ADDR_W-1:0] r_im_addr,    w_im_addr_nxt;
    logic              r_inst_valid, w_inst_valid_nxt;
    logic [INST_W-1:0] r_inst_out,   w_inst_out_nxt;
    logic [ADDR_W-1:0] r_pc_out,     w_pc_out_nxt;
    logic              r_squash,     w_squash_nxt;
    logic              r_fetch_err,  w_fetch_err_nxt;

    logic              w_tmo_en;
    logic              w_tmo_clr;
    logic              w_tmo_expired;

    if_fetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (w_tmo_en),
        .i_clr     (w_tmo_clr),
        .o_expired (w_tmo_expired)
    );

    // State and output registers; reset abandons any fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_im_req     <= 1'b0;
            r_im_addr    <= '0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= INST_W'(NOP_INST);
            r_pc_out     <= '0;
            r_squash     <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_im_req     <= w_im_req_nxt;
            r_im_addr    <= w_im_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_squash     <= w_squash_nxt;
            r_fetch_err  <= w_fetch_err_nxt;
        end
    end

    // Next-state and next-register logic; everything holds unless a branch below changes it
    always_comb begin
        w_state_nxt      = r_state;
        w_im_req_nxt     = r_im_req;
        w_im_addr_nxt    = r_im_addr;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_out_nxt   = r_inst_out;
        w_pc_out_nxt     = r_pc_out;
        w_squash_nxt     = r_squash;
        w_fetch_err_nxt  = r_fetch_err;
        w_tmo_en         = 1'b0;
        w_tmo_clr        = 1'b0;

        case (r_state)
            IDLE: begin
                if (fetch_en) begin
                    w_im_addr_nxt = pc_in;
                    w_im_req_nxt  = 1'b1;
                    w_squash_nxt  = 1'b0;
                    w_tmo_clr     = 1'b1;
                    w_state_nxt   = WAIT;
                end
            end

            WAIT: begin
                // The memory handshake is never aborted; a redirect only marks the word for discard
                if (redirect) begin
                    w_squash_nxt = 1'b1;
                end
                if (im_ready) begin
                    w_im_req_nxt = 1'b0;
                    if (r_squash || redirect) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_inst_out_nxt   = im_rdata;
                        w_pc_out_nxt     = r_im_addr;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = HOLD;
                    end
                end else begin
                    w_tmo_en = 1'b1;
                    if (w_tmo_expired) begin
                        w_im_req_nxt    = 1'b0;
                        w_fetch_err_nxt = 1'b1;
                        w_state_nxt     = ERR;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = IDLE;
                end else if (id_ready) begin
                    w_inst_valid_nxt = 1'b0;
                    // Back-to-back issue: behaves exactly like the IDLE launch
                    if (fetch_en) begin
                        w_im_addr_nxt = pc_in;
                        w_im_req_nxt  = 1'b1;
                        w_squash_nxt  = 1'b0;
                        w_tmo_clr     = 1'b1;
                        w_state_nxt   = WAIT;
                    end else begin
                        w_state_nxt   = IDLE;
                    end
                end
            end

            ERR: begin
                w_im_req_nxt     = 1'b0;
                w_inst_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign fetch_stall = (r_state == WAIT)
                       | ((r_state == HOLD) & ~id_ready)
                       | (r_state == ERR);

    assign im_req     = r_im_req;
    assign im_addr    = r_im_addr;
    assign inst_valid = r_inst_valid;
    assign inst_out   = r_inst_out;
    assign pc_out     = r_pc_out;
    assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl (TIMEOUT_CYCLES = 4).
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        fetch_en;
    logic        redirect;
    logic        id_ready;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        fetch_stall;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    if_fetch_ctrl #(
        .ADDR_W         (32),
        .INST_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .id_ready    (id_ready),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ready    (im_ready),
        .im_rdata    (im_rdata),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .fetch_stall (fetch_stall),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 ns after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".im_req"},      im_req,      0);
        check({tag, ".im_addr"},     im_addr,     0);
        check({tag, ".inst_valid"},  inst_valid,  0);
        check({tag, ".inst_out"},    inst_out,    32'h0000_0013);
        check({tag, ".pc_out"},      pc_out,      0);
        check({tag, ".fetch_err"},   fetch_err,   0);
        check({tag, ".fetch_stall"}, fetch_stall, 0);
    endtask

    initial begin
        rst      = 1'b1;
        pc_in    = '0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        im_ready = 1'b0;
        im_rdata = '0;
        #1;
        check_reset_outputs("rst0");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("idle0");

        // ---- 1: basic fetch, memory acks 2 cycles after request
        pc_in    = 32'h100;
        fetch_en = 1'b1;
        im_rdata = 32'h0050_0093;
        tick();
        fetch_en = 1'b0;
        check("t1.im_req",   im_req,      1);
        check("t1.im_addr",  im_addr,     32'h100);
        check("t1.stall_w",  fetch_stall, 1);
        tick();
        check("t1.addr_hold", im_addr,    32'h100);
        im_ready = 1'b1;
        #1;
        check("t1.no_valid_yet", inst_valid, 0);
        tick();
        im_ready = 1'b0;
        check("t1.valid",    inst_valid,  1);
        check("t1.inst",     inst_out,    32'h0050_0093);
        check("t1.pc",       pc_out,      32'h100);
        check("t1.req_drop", im_req,      0);
        check("t1.stall_h",  fetch_stall, 1);
        id_ready = 1'b1;
        #1;
        check("t1.stall_rdy", fetch_stall, 0);
        tick();
        id_ready = 1'b0;
        check("t1.consumed", inst_valid,  0);
        check("t1.idle_req", im_req,      0);

        // ---- 2: redirect pulse during WAIT squashes the later response
        pc_in    = 32'h200;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t2.im_addr", im_addr, 32'h200);
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        check("t2.still_req", im_req, 1);
        im_ready = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ready = 1'b0;
        check("t2.req_drop", im_req,      0);
        check("t2.no_valid", inst_valid,  0);
        check("t2.inst_kept", inst_out,   32'h0050_0093);
        check("t2.idle",     fetch_stall, 0);
        pc_in    = 32'h300;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t2.refetch_req",  im_req,  1);
        check("t2.refetch_addr", im_addr, 32'h300);

        // ---- 3: im_ready and redirect in the same cycle
        im_ready = 1'b1;
        redirect = 1'b1;
        im_rdata = 32'h1234_5678;
        tick();
        im_ready = 1'b0;
        redirect = 1'b0;
        check("t3.req_drop", im_req,     0);
        check("t3.no_valid", inst_valid, 0);
        check("t3.inst_kept", inst_out,  32'h0050_0093);
        tick();
        check("t3.no_valid2", inst_valid, 0);

        // ---- 4: HOLD under back-pressure, then back-to-back fetch
        pc_in    = 32'h400;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        im_ready = 1'b1;
        im_rdata = 32'h00A0_0113;
        tick();
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4.valid", inst_valid,  1);
            check("t4.inst",  inst_out,    32'h00A0_0113);
            check("t4.pc",    pc_out,      32'h400);
            check("t4.stall", fetch_stall, 1);
            tick();
        end
        check("t4.valid_end", inst_valid, 1);
        id_ready = 1'b1;
        fetch_en = 1'b1;
        pc_in    = 32'h404;
        #1;
        check("t4.stall_rel", fetch_stall, 0);
        tick();
        id_ready = 1'b0;
        fetch_en = 1'b0;
        check("t4.next_req",  im_req,     1);
        check("t4.next_addr", im_addr,    32'h404);
        check("t4.valid_clr", inst_valid, 0);
        im_ready = 1'b1;
        im_rdata = 32'h0001_0001;
        tick();
        im_ready = 1'b0;
        check("t4.valid2", inst_valid, 1);
        check("t4.pc2",    pc_out,     32'h404);
        redirect = 1'b1;
        id_ready = 1'b1;
        fetch_en = 1'b1;
        pc_in    = 32'h408;
        tick();
        redirect = 1'b0;
        id_ready = 1'b0;
        fetch_en = 1'b0;
        check("t4.redir_drop",  inst_valid,  0);
        check("t4.redir_noreq", im_req,      0);
        check("t4.redir_idle",  fetch_stall, 0);

        // ---- 5: timeout after 4 WAIT cycles
        pc_in    = 32'h500;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        tick();
        check("t5.err_early", fetch_err, 0);
        check("t5.req_early", im_req,    1);
        tick();
        check("t5.err",      fetch_err,   1);
        check("t5.req_off",  im_req,      0);
        check("t5.stall",    fetch_stall, 1);
        check("t5.no_valid", inst_valid,  0);
        fetch_en = 1'b1;
        tick();
        tick();
        fetch_en = 1'b0;
        check("t5.err_stick",  fetch_err,   1);
        check("t5.req_stuck",  im_req,      0);
        check("t5.stall_stk",  fetch_stall, 1);

        // ---- 6: asynchronous reset from ERR and from WAIT
        rst = 1'b1;
        #1;
        check("t6.err_clr",   fetch_err,   0);
        check("t6.stall_clr", fetch_stall, 0);
        tick();
        rst = 1'b0;
        tick();
        pc_in    = 32'h600;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t6.req_wait", im_req, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6.async");
        tick();
        rst = 1'b0;
        im_ready = 1'b1;
        im_rdata = 32'hCAFE_F00D;
        tick();
        im_ready = 1'b0;
        check("t6.no_resp", inst_valid, 0);
        check("t6.inst_nop", inst_out,  32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
